// File: rtl/swap_datapath.sv
// Three-register datapath on a shared bus, driven by the swap controller's
// load/drive enables, with an external seeding port and a swap-sequence tracker.
module swap_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             c1,
   input  logic             c2,
   input  logic             c3,
   input  logic             h1,
   input  logic             h2,
   input  logic             h3,
   input  logic             done,
   input  logic             ld_en,
   input  logic [1:0]       ld_sel,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] bus,
   output logic             bus_err,
   output logic             ld_ack,
   output logic             ld_rej,
   output logic             swap_done,
   output logic             swap_ok,
   output logic             seq_err,
   output logic [7:0]       swap_cnt
);

   typedef enum logic [1:0] {T_IDLE, T_B, T_C} trk_t;

   trk_t             trk_q, trk_d;
   logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
   logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [7:0]       swap_cnt_q, swap_cnt_d;
   logic             swap_ok_q, swap_ok_d;
   logic             swap_done_q, swap_done_d;
   logic             seq_err_q, seq_err_d;
   logic             ld_ack_q, ld_ack_d;
   logic             ld_rej_q, ld_rej_d;

   logic [2:0] cv, hv;
   logic       any_ctl, ld_ok, op_b, op_c, op_d;

   always_comb begin
      cv      = {c3, c2, c1};
      hv      = {h3, h2, h1};
      any_ctl = |{cv, hv};
      bus_err = (hv & (hv - 3'd1)) != 3'd0;
      case (hv)
         3'b001:  bus = r1_q;
         3'b010:  bus = r2_q;
         3'b100:  bus = r3_q;
         default: bus = '0;
      endcase
      op_b  = (cv == 3'b100) && (hv == 3'b010);
      op_c  = (cv == 3'b010) && (hv == 3'b001);
      op_d  = (cv == 3'b001) && (hv == 3'b100);
      ld_ok = ld_en && done && !any_ctl && (ld_sel != 2'd0);
   end

   // Register file: bus loads are blocked on contention; external loads only when no c/h is active
   always_comb begin
      r1_d     = r1_q;
      r2_d     = r2_q;
      r3_d     = r3_q;
      ld_ack_d = ld_ok;
      ld_rej_d = ld_en && !ld_ok;
      if (!bus_err) begin
         if (c1) r1_d = bus;
         if (c2) r2_d = bus;
         if (c3) r3_d = bus;
      end
      if (ld_ok) begin
         case (ld_sel)
            2'd1:    r1_d = ld_data;
            2'd2:    r2_d = ld_data;
            2'd3:    r3_d = ld_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      trk_d       = trk_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      swap_cnt_d  = swap_cnt_q;
      swap_ok_d   = swap_ok_q;
      swap_done_d = 1'b0;
      seq_err_d   = 1'b0;
      case (trk_q)
         T_IDLE: begin
            if (op_b) begin
               trk_d = T_B;
               s1_d  = r1_q;
               s2_d  = r2_q;
            end else if (any_ctl) begin
               seq_err_d = 1'b1;
            end
         end
         T_B: begin
            if (op_c && !done) begin
               trk_d = T_C;
            end else begin
               trk_d     = T_IDLE;
               seq_err_d = 1'b1;
            end
         end
         T_C: begin
            trk_d = T_IDLE;
            if (op_d) begin
               swap_done_d = 1'b1;
               swap_cnt_d  = swap_cnt_q + 8'd1;
               // Verify against the values the registers take at this edge
               swap_ok_d   = (r1_d == s2_q) && (r2_d == s1_q);
            end else begin
               seq_err_d = 1'b1;
            end
         end
         default: trk_d = T_IDLE;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         trk_q       <= T_IDLE;
         r1_q        <= '0;
         r2_q        <= '0;
         r3_q        <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         swap_cnt_q  <= 8'd0;
         swap_ok_q   <= 1'b0;
         swap_done_q <= 1'b0;
         seq_err_q   <= 1'b0;
         ld_ack_q    <= 1'b0;
         ld_rej_q    <= 1'b0;
      end else begin
         trk_q       <= trk_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         r3_q        <= r3_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         swap_cnt_q  <= swap_cnt_d;
         swap_ok_q   <= swap_ok_d;
         swap_done_q <= swap_done_d;
         seq_err_q   <= seq_err_d;
         ld_ack_q    <= ld_ack_d;
         ld_rej_q    <= ld_rej_d;
      end
   end

   assign r1        = r1_q;
   assign r2        = r2_q;
   assign r3        = r3_q;
   assign swap_cnt  = swap_cnt_q;
   assign swap_ok   = swap_ok_q;
   assign swap_done = swap_done_q;
   assign seq_err   = seq_err_q;
   assign ld_ack    = ld_ack_q;
   assign ld_rej    = ld_rej_q;

endmodule

// File: tb/tb_swap_datapath.sv
// Directed vector bench for swap_datapath: a table of single-cycle vectors
// followed by a 256-swap wrap sequence.
module tb_swap_datapath;

   logic       ck = 1'b0;
   logic       rst, c1, c2, c3, h1, h2, h3, done, ld_en;
   logic [1:0] ld_sel;
   logic [7:0] ld_data;
   logic [7:0] r1, r2, r3, bus, swap_cnt;
   logic       bus_err, ld_ack, ld_rej, swap_done, swap_ok, seq_err;

   int checks = 0;
   int errors = 0;

   always #5 ck = ~ck;

   swap_datapath #(.WIDTH(8)) dut (
      .ck(ck), .rst(rst), .c1(c1), .c2(c2), .c3(c3), .h1(h1), .h2(h2), .h3(h3),
      .done(done), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
      .r1(r1), .r2(r2), .r3(r3), .bus(bus), .bus_err(bus_err),
      .ld_ack(ld_ack), .ld_rej(ld_rej), .swap_done(swap_done),
      .swap_ok(swap_ok), .seq_err(seq_err), .swap_cnt(swap_cnt)
   );

   typedef struct {
      logic       rst;
      logic [2:0] c;    // {c3,c2,c1}
      logic [2:0] h;    // {h3,h2,h1}
      logic       done, en;
      logic [1:0] sel;
      logic [7:0] d;
      logic [7:0] ebus;
      logic       eberr;
      logic [7:0] er1, er2, er3;
      logic       eack, erej, esd, esok, eserr;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rst_i, input logic [2:0] c, input logic [2:0] h,
      input logic dn, input logic en, input logic [1:0] sel, input logic [7:0] d,
      input logic [7:0] ebus, input logic eberr,
      input logic [7:0] er1, input logic [7:0] er2, input logic [7:0] er3,
      input logic eack, input logic erej, input logic esd, input logic esok,
      input logic eserr, input logic [7:0] ecnt);
      vec_t v;
      v.rst = rst_i; v.c = c; v.h = h; v.done = dn; v.en = en; v.sel = sel; v.d = d;
      v.ebus = ebus; v.eberr = eberr; v.er1 = er1; v.er2 = er2; v.er3 = er3;
      v.eack = eack; v.erej = erej; v.esd = esd; v.esok = esok; v.eserr = eserr;
      v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d] got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [2:0] c, input logic [2:0] h,
                        input logic dn, input logic en, input logic [1:0] sel,
                        input logic [7:0] d);
      @(negedge ck);
      rst = r; {c3, c2, c1} = c; {h3, h2, h1} = h;
      done = dn; ld_en = en; ld_sel = sel; ld_data = d;
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v.rst, v.c, v.h, v.done, v.en, v.sel, v.d);
      #1;
      chk("bus", idx, {24'd0, bus}, {24'd0, v.ebus});
      chk("bus_err", idx, {31'd0, bus_err}, {31'd0, v.eberr});
      @(posedge ck);
      #1;
      chk("r1", idx, {24'd0, r1}, {24'd0, v.er1});
      chk("r2", idx, {24'd0, r2}, {24'd0, v.er2});
      chk("r3", idx, {24'd0, r3}, {24'd0, v.er3});
      chk("ld_ack", idx, {31'd0, ld_ack}, {31'd0, v.eack});
      chk("ld_rej", idx, {31'd0, ld_rej}, {31'd0, v.erej});
      chk("swap_done", idx, {31'd0, swap_done}, {31'd0, v.esd});
      chk("swap_ok", idx, {31'd0, swap_ok}, {31'd0, v.esok});
      chk("seq_err", idx, {31'd0, seq_err}, {31'd0, v.eserr});
      chk("swap_cnt", idx, {24'd0, swap_cnt}, {24'd0, v.ecnt});
   endtask

   localparam logic [2:0] Z = 3'b000;
   localparam logic [2:0] BC = 3'b100, BH = 3'b010;  // OP_B: c3 & h2
   localparam logic [2:0] CC = 3'b010, CH = 3'b001;  // OP_C: c2 & h1
   localparam logic [2:0] DC = 3'b001, DH = 3'b100;  // OP_D: c1 & h3

   initial begin
      rst = 1'b0; {c3, c2, c1} = Z; {h3, h2, h1} = Z;
      done = 1'b0; ld_en = 1'b0; ld_sel = 2'd0; ld_data = 8'd0;

      //               rst c   h   dn en sel data    bus    be  r1     r2     r3     ak rj sd ok se cnt
      vecs.push_back(mk(1, Z,  Z,  0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, Z,  Z,  1, 0, 0, 8'h00,  8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, Z,  Z,  1, 1, 1, 8'h11,  8'h00, 0, 8'h11, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, Z,  Z,  1, 1, 2, 8'h22,  8'h00, 0, 8'h11, 8'h22, 8'h00, 1, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, BC, BH, 0, 0, 0, 8'h00,  8'h22, 0, 8'h11, 8'h22, 8'h22, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, CC, CH, 0, 0, 0, 8'h00,  8'h11, 0, 8'h11, 8'h11, 8'h22, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, DC, DH, 0, 0, 0, 8'h00,  8'h22, 0, 8'h22, 8'h11, 8'h22, 0, 0, 1, 1, 0, 8'd1));
      vecs.push_back(mk(0, Z,  Z,  0, 1, 1, 8'h55,  8'h00, 0, 8'h22, 8'h11, 8'h22, 0, 1, 0, 1, 0, 8'd1));
      vecs.push_back(mk(0, Z,  Z,  1, 1, 0, 8'h55,  8'h00, 0, 8'h22, 8'h11, 8'h22, 0, 1, 0, 1, 0, 8'd1));
      vecs.push_back(mk(0, 3'b100, 3'b011, 0, 0, 0, 8'h00, 8'h00, 1, 8'h22, 8'h11, 8'h22, 0, 0, 0, 1, 1, 8'd1));
      vecs.push_back(mk(0, BC, BH, 0, 0, 0, 8'h00,  8'h11, 0, 8'h22, 8'h11, 8'h11, 0, 0, 0, 1, 0, 8'd1));
      vecs.push_back(mk(0, Z,  Z,  0, 0, 0, 8'h00,  8'h00, 0, 8'h22, 8'h11, 8'h11, 0, 0, 0, 1, 1, 8'd1));
      vecs.push_back(mk(0, BC, BH, 0, 0, 0, 8'h00,  8'h11, 0, 8'h22, 8'h11, 8'h11, 0, 0, 0, 1, 0, 8'd1));
      vecs.push_back(mk(0, CC, CH, 0, 0, 0, 8'h00,  8'h22, 0, 8'h22, 8'h22, 8'h11, 0, 0, 0, 1, 0, 8'd1));
      vecs.push_back(mk(0, DC, DH, 0, 0, 0, 8'h00,  8'h11, 0, 8'h11, 8'h22, 8'h11, 0, 0, 1, 1, 0, 8'd2));
      vecs.push_back(mk(0, BC, BH, 0, 0, 0, 8'h00,  8'h22, 0, 8'h11, 8'h22, 8'h22, 0, 0, 0, 1, 0, 8'd2));
      vecs.push_back(mk(0, CC, CH, 0, 0, 0, 8'h00,  8'h11, 0, 8'h11, 8'h11, 8'h22, 0, 0, 0, 1, 0, 8'd2));
      vecs.push_back(mk(1, Z,  Z,  0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, DC, DH, 0, 0, 0, 8'h00,  8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'd0));
      vecs.push_back(mk(0, CC, CH, 1, 1, 2, 8'h77,  8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1, 8'd0));
      vecs.push_back(mk(0, Z,  Z,  1, 1, 3, 8'h99,  8'h00, 0, 8'h00, 8'h00, 8'h99, 1, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, Z,  Z,  1, 1, 1, 8'h5A,  8'h00, 0, 8'h5A, 8'h00, 8'h99, 1, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, BC, BH, 0, 0, 0, 8'h00,  8'h00, 0, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, CC, CH, 0, 0, 0, 8'h00,  8'h5A, 0, 8'h5A, 8'h5A, 8'h00, 0, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk(0, BC, BH, 0, 0, 0, 8'h00,  8'h5A, 0, 8'h5A, 8'h5A, 8'h5A, 0, 0, 0, 0, 1, 8'd0));
      vecs.push_back(mk(0, CC, CH, 0, 0, 0, 8'h00,  8'h5A, 0, 8'h5A, 8'h5A, 8'h5A, 0, 0, 0, 0, 1, 8'd0));

      foreach (vecs[i]) apply(vecs[i], i);

      // 256 back-to-back swaps from a fresh reset; counter wraps to 0, R1/R2 return home
      drive(1, Z, Z, 0, 0, 0, 8'h00);
      drive(0, Z, Z, 1, 1, 1, 8'hA1);
      drive(0, Z, Z, 1, 1, 2, 8'hB2);
      for (int n = 1; n <= 256; n++) begin
         drive(0, BC, BH, 0, 0, 0, 8'h00);
         drive(0, CC, CH, 0, 0, 0, 8'h00);
         drive(0, DC, DH, 0, 0, 0, 8'h00);
         @(posedge ck);
         #1;
         chk("wrap_done", n, {31'd0, swap_done}, 32'd1);
         chk("wrap_ok", n, {31'd0, swap_ok}, 32'd1);
         chk("wrap_seq_err", n, {31'd0, seq_err}, 32'd0);
         chk("wrap_cnt", n, {24'd0, swap_cnt}, n % 256);
         chk("wrap_r1", n, {24'd0, r1}, (n % 2 == 1) ? 32'hB2 : 32'hA1);
         chk("wrap_r2", n, {24'd0, r2}, (n % 2 == 1) ? 32'hA1 : 32'hB2);
      end
      drive(0, Z, Z, 1, 0, 0, 8'h00);
      @(posedge ck);
      #1;
      chk("wrap_done_drop", 0, {31'd0, swap_done}, 32'd0);
      chk("wrap_ok_hold", 0, {31'd0, swap_ok}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
